// File: rtl/surv_trace_out.sv
// Survivor trace-out: buffers one 8-word survivor group and streams the selected decision byte MSB first.
// Optional feature macro SURV_MAJ_VOTE_EN: majority vote across all 32 bytes instead of the best_sel lane.
module surv_trace_out #(
    parameter int GRP = 8,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic          sync_in,
    input  logic [4:0]    best_sel,
    output logic          out_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [4:0]    sel_q, sel_d;
    logic          overrun_q, overrun_d;
    logic [DW-1:0] buf_q [GRP];

    logic          wr_en;
    logic [2:0]    wr_idx;
    logic          accept;
    logic [2:0]    bit_idx;
    logic          dec_bit;

    assign accept  = (state_q == EMIT) && out_ready;
    assign bit_idx = 3'd7 - bcnt_q;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        bcnt_d    = bcnt_q;
        sel_d     = sel_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
        wr_idx    = wcnt_q;

        case (state_q)
            IDLE: begin
                if (sync_in) begin
                    wr_en   = 1'b1;
                    wr_idx  = 3'd0;
                    wcnt_d  = 3'd1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                wr_en = 1'b1;
                if (sync_in) begin
                    // A fresh sync restarts the group; the partial one is silently discarded.
                    wr_idx = 3'd0;
                    wcnt_d = 3'd1;
                end else begin
                    wr_idx = wcnt_q;
                    wcnt_d = wcnt_q + 3'd1;
                    if (wcnt_q == 3'd7) begin
                        sel_d   = best_sel;
                        bcnt_d  = 3'd0;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (accept && (bcnt_q == 3'd7)) begin
                    bcnt_d = 3'd0;
                    if (sync_in) begin
                        wr_en   = 1'b1;
                        wr_idx  = 3'd0;
                        wcnt_d  = 3'd1;
                        state_d = CAPTURE;
                    end else begin
                        wcnt_d  = 3'd0;
                        state_d = IDLE;
                    end
                end else begin
                    if (accept) begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                    // The buffer is still busy, so an incoming group is lost and flagged.
                    if (sync_in) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= 3'd0;
            bcnt_q    <= 3'd0;
            sel_q     <= 5'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            bcnt_q    <= bcnt_d;
            sel_q     <= sel_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the group buffer is small register storage, so it is reset to a known zero state
    // rather than inferred as an unreset RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GRP; i++) begin
                buf_q[i] <= '0;
            end
        end else if (wr_en) begin
            buf_q[wr_idx] <= data_in;
        end
    end

`ifdef SURV_MAJ_VOTE_EN
    logic [5:0] ones;

    always_comb begin
        ones = 6'd0;
        for (int w = 0; w < GRP; w++) begin
            for (int b = 0; b < DW / 8; b++) begin
                ones = ones + 6'(buf_q[w][b * 8 + int'(bit_idx)]);
            end
        end
    end

    assign dec_bit = (ones >= 6'd16);
`else
    logic [7:0] sel_byte;

    assign sel_byte = buf_q[sel_q[4:2]][{sel_q[1:0], 3'b000} +: 8];
    assign dec_bit  = sel_byte[bit_idx];
`endif

    assign out_valid = (state_q == EMIT);
    assign out_bit   = out_valid && dec_bit;
    assign out_last  = out_valid && (bcnt_q == 3'd7);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_surv_trace_out.sv
// Directed bench for surv_trace_out; expected bits are queued when a group is driven and
// compared as the consumer accepts them. Honours SURV_MAJ_VOTE_EN in its reference model.
module tb_surv_trace_out;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        sync_in;
    logic [4:0]  best_sel;
    logic        out_bit;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overrun;

    typedef struct packed {
        logic val;
        logic last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] grp_w [8];
    logic [4:0]  grp_sel;

    surv_trace_out dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sync_in   (sync_in),
        .best_sel  (best_sel),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: lane byte, or per-bit majority over the 32 bytes when voting is enabled.
    function automatic logic [7:0] model_byte();
        logic [7:0] r;
`ifdef SURV_MAJ_VOTE_EN
        for (int k = 0; k < 8; k++) begin
            int cnt = 0;
            for (int w = 0; w < 8; w++)
                for (int b = 0; b < 4; b++)
                    cnt += int'(grp_w[w][b * 8 + k]);
            r[k] = (cnt >= 16);
        end
`else
        r = grp_w[grp_sel[4:2]][grp_sel[1:0] * 8 +: 8];
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) grp_w[i] = $urandom;
        grp_sel = 5'($urandom_range(0, 31));
    endtask

    task automatic fill_bytes(input int n_ff);
        for (int n = 0; n < 32; n++)
            grp_w[n / 4][(n % 4) * 8 +: 8] = (n < n_ff) ? 8'hFF : 8'h00;
    endtask

    // Drives words 0..7 (cycles 0..7) and leaves the bench in cycle 8.
    task automatic send_group();
        logic [7:0] eb;
        for (int i = 0; i < 8; i++) begin
            sync_in  = (i == 0);
            data_in  = grp_w[i];
            best_sel = (i == 7) ? grp_sel : ~grp_sel;
            if (i == 7) begin
                check("pre_latency_valid", out_valid, 1'b0);
                eb = model_byte();
                for (int k = 0; k < 8; k++) exp_q.push_back('{val: eb[7 - k], last: (k == 7)});
            end
            step();
        end
        sync_in  = 1'b0;
        data_in  = '0;
        best_sel = '0;
        check("latency_valid", out_valid, 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            step();
            n++;
        end
        check("drain", (exp_q.size() == 0) && !out_valid, 1'b1);
    endtask

    // Consumer side: compare each accepted bit against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_bit", out_valid, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_bit", out_bit, e.val);
                check("out_last", out_last, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; sync_in = 1'b0; data_in = '0; best_sel = '0; out_ready = 1'b1;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_bit", out_bit, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        step(); step();
        rst = 1'b0;

        // Basic group: word 5 byte 2 = A5 -> 1,0,1,0,0,1,0,1.
        fill_random();
        grp_w[5] = 32'h00A5_0000;
        grp_sel  = 5'b10110;
        send_group();
        wait_drain();

        // Back-to-back: next sync lands on the 8th accept (cycle 15).
        fill_random();
        send_group();
        for (int c = 8; c < 15; c++) step();
        check("b2b_last_pending", out_last, 1'b1);
        fill_random();
        send_group();
        check("b2b_no_overrun", overrun, 1'b0);
        wait_drain();

        // Backpressure cycles 8..12 with an overrunning sync at cycle 10.
        fill_random();
        grp_w[5] = 32'h00A5_0000;
        grp_sel  = 5'b10110;
        out_ready = 1'b0;
        send_group();
        for (int c = 8; c <= 12; c++) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_last", out_last, 1'b0);
            if (exp_q.size() != 0) check("hold_bit", out_bit, exp_q[0].val);
            sync_in = (c == 10);
            data_in = (c == 10) ? 32'hFFFF_FFFF : 32'h0;
            step();
            if (c >= 10) check("overrun_set", overrun, 1'b1);
        end
        sync_in   = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        wait_drain();
        check("overrun_sticky", overrun, 1'b1);

        // Reset after three accepted bits.
        fill_random();
        send_group();
        step(); step(); step();
        rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_overrun", overrun, 1'b0);
        exp_q.delete();
        step();
        rst = 1'b0;
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                seen |= out_valid;
                step();
            end
            check("post_rst_quiet", seen, 1'b0);
        end
        fill_random();
        send_group();
        wait_drain();

        // Sync on the first edge after reset release.
        rst = 1'b1;
        step();
        rst = 1'b0;
        fill_random();
        send_group();
        wait_drain();

`ifdef SURV_MAJ_VOTE_EN
        fill_bytes(20);
        grp_sel = 5'd0;
        send_group();
        wait_drain();
        fill_bytes(15);
        grp_sel = 5'd31;
        send_group();
        wait_drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/surv_trace_out.md
SURV_TRACE_OUT -- requirements
Module: surv_trace_out

Interface
REQ-001 Parameter: GRP, 8, survivor words per group; fixed to 8, and no other value is supported.
REQ-002 Parameter: DW, 32, survivor word width; fixed to 32 (4 bytes of 8 decision bits).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: data_in  input  32  survivor word from the upstream survivor shift-memory output selector, one word per cycle.
REQ-006 Port: sync_in  input  1  high on the cycle data_in carries word 0 of a group.
REQ-007 Port: best_sel  input  5  winning lane: [4:2] word index 0..7, [1:0] byte index 0..3; sampled with word 7.
REQ-008 Port: out_bit  output  1  decoded bit.
REQ-009 Port: out_valid  output  1  out_bit valid.
REQ-010 Port: out_ready  input  1  consumer accepts out_bit when out_valid and out_ready are both high.
REQ-011 Port: out_last  output  1  high with the 8th (final) bit of a group.
REQ-012 Port: overrun  output  1  sticky flag: a group was dropped.

Function
REQ-013 FSM states: IDLE, CAPTURE, EMIT.
REQ-014 IDLE + sync_in: store data_in as word 0, set wcnt=1, and go to CAPTURE; otherwise stay in IDLE and ignore data_in.
REQ-015 CAPTURE: store data_in at wcnt and increment wcnt (3-bit). When word 7 is stored, latch best_sel and go to EMIT.
REQ-016 sync_in during CAPTURE: restart the group, storing data_in as word 0 and setting wcnt=1. The partial group is discarded without flagging.
REQ-017 Group buffer: 8x32 register array. Selected byte = word[best_sel[4:2]] byte[best_sel[1:0]].
REQ-018 Latency: sync_in at cycle 0 -> out_valid high from cycle 8.
REQ-019 EMIT: out_bit = selected byte bit (7-bcnt), i.e. bit 7 (oldest decision) first. bcnt (3-bit) advances only on handshake.
REQ-020 out_valid stays high and out_bit stable until accepted; out_ready low holds all outputs.
REQ-021 out_last = out_valid and bcnt==7.
REQ-022 After the 8th accept: if sync_in is high that same cycle, capture it as word 0 and go to CAPTURE; else go to IDLE.
REQ-023 sync_in during EMIT other than on the final accept: drop the group, set overrun=1, and leave the buffer and outputs unaffected.
REQ-024 overrun clears only on reset.
REQ-025 out_valid is low in IDLE and CAPTURE.

Reset
REQ-026 rst high: state=IDLE, wcnt=0, bcnt=0, out_valid=0, out_bit=0, out_last=0, overrun=0, buffer cleared to 0, latched best_sel=0.
REQ-027 Reset mid-CAPTURE or mid-EMIT aborts the group immediately. No bit is emitted after rst rises.
REQ-028 On release, the first sync_in is accepted on the first rising edge where rst is low.

Configuration
REQ-029 Macro SURV_MAJ_VOTE_EN.
- Defined: each out_bit is the majority of bit (7-bcnt) across all 32 bytes of the group; a count >=16 ones gives 1. best_sel is ignored, and latency and handshake are unchanged.
- Undefined: lane selection per REQ-017/019 applies, and no vote logic is built.

Verification
REQ-030 Basic: sync_in with words 0..7; word 5 = 32'h00A5_0000; best_sel=5'b10110 (word 5, byte 2); out_ready=1 -> out_valid at cycle 8; bits 1,0,1,0,0,1,0,1; out_last with the 8th bit.
REQ-031 Backpressure: same stimulus, out_ready low cycles 8-12 -> out_bit=1 held, bcnt=0, out_valid held; emission resumes cycle 13 and completes at cycle 20.
REQ-032 Overrun: sync_in at cycle 10 with out_ready=0 -> overrun=1 and stays high; the pending byte still emits unchanged.
REQ-033 Back-to-back: sync_in on the cycle of the 8th accept -> no overrun; the next group's first bit is valid 8 cycles later.
REQ-034 Reset mid-EMIT: rst pulse after 3 bits accepted -> out_valid=0 the same cycle; no further bits until a new sync_in plus 8 cycles.
REQ-035 SURV_MAJ_VOTE_EN defined: 20 bytes=8'hFF, 12 bytes=8'h00 -> eight 1s. With 15 bytes 8'hFF and 17 bytes 8'h00 -> eight 0s.
